// File: rtl/liang_pkg.sv
// Shared types for the instruction fetch unit: PC/decode handoff types, reset PC and FSM encoding.
package liang_pkg;

   typedef logic [31:0] pc_t;

   typedef struct packed {
      pc_t         pc;
      logic [31:0] inst;
   } ifToId_t;

   localparam pc_t RESET_PC_DEFAULT = 32'h8000_0000;

   typedef enum logic [1:0] {
      IFU_IDLE = 2'd0,
      IFU_REQ  = 2'd1,
      IFU_WAIT = 2'd2,
      IFU_HOLD = 2'd3
   } ifu_state_e;

   // Redirect targets may carry low bits; fetch is always word aligned.
   function automatic pc_t align_pc(input pc_t pc);
      return pc & ~pc_t'(3);
   endfunction

endpackage

// File: rtl/ifu_perf_cnt.sv
// Fetch unit event counters: decode handoffs and discarded instructions, both wrapping.
// Latency: count visible the cycle after the event; never stalls anything.
module ifu_perf_cnt (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        fetch_inc_i,
   input  logic        drop_inc_i,
   output logic [31:0] fetch_cnt_o,
   output logic [31:0] drop_cnt_o
);

   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q + {31'd0, fetch_inc_i};
      drop_cnt_d  = drop_cnt_q + {31'd0, drop_inc_i};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign fetch_cnt_o = fetch_cnt_q;
   assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: rtl/pipe_ifu.sv
// Single-outstanding instruction fetch FSM (IDLE/REQ/WAIT/HOLD); IFU_PERF_CNT_EN adds perf counters.
// Latency: registered handoff one cycle after response; HOLD stalls fetch until id_ready_i, flush wins always.
module pipe_ifu
   import liang_pkg::*;
#(
   parameter pc_t RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        flush_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_valid_o,
   output logic [31:0] imem_req_addr_o,
   input  logic        imem_req_ready_i,
   input  logic        imem_rsp_valid_i,
   input  logic [31:0] imem_rsp_data_i,
   output ifToId_t     ifToId_o,
   output logic        if_valid_o,
   input  logic        id_ready_i
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt_o,
   output logic [31:0] drop_cnt_o
`endif
);

   localparam logic [1:0] ST_IDLE = IFU_IDLE;
   localparam logic [1:0] ST_REQ  = IFU_REQ;
   localparam logic [1:0] ST_WAIT = IFU_WAIT;
   localparam logic [1:0] ST_HOLD = IFU_HOLD;

   logic [1:0] state_q, state_d;
   pc_t        pc_q, pc_d;
   logic       drop_q, drop_d;
   ifToId_t    out_q, out_d;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      drop_d  = drop_q;
      out_d   = out_q;

      case (state_q)
         ST_IDLE: state_d = ST_REQ;
         ST_REQ: begin
            if (imem_req_ready_i) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (imem_rsp_valid_i) begin
               if (drop_q) begin
                  state_d = ST_REQ;
                  drop_d  = 1'b0;
               end else begin
                  out_d   = '{pc: pc_q, inst: imem_rsp_data_i};
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (id_ready_i) begin
               pc_d    = pc_q + 32'd4;
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A request accepted in the flush cycle is still in flight, so its response must be dropped.
      if (flush_i) begin
         pc_d  = align_pc(redirect_pc_i);
         out_d = out_q;
         case (state_q)
            ST_REQ: begin
               if (imem_req_ready_i) begin
                  state_d = ST_WAIT;
                  drop_d  = 1'b1;
               end else begin
                  state_d = ST_REQ;
               end
            end
            ST_WAIT: begin
               if (imem_rsp_valid_i) begin
                  state_d = ST_REQ;
                  drop_d  = 1'b0;
               end else begin
                  state_d = ST_WAIT;
                  drop_d  = 1'b1;
               end
            end
            default: state_d = ST_REQ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         drop_q  <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         drop_q  <= drop_d;
         out_q   <= out_d;
      end
   end

   assign imem_req_valid_o = (state_q == ST_REQ);
   assign imem_req_addr_o  = pc_q;
   assign ifToId_o         = out_q;
   assign if_valid_o       = (state_q == ST_HOLD) && !flush_i;

`ifdef IFU_PERF_CNT_EN
   logic fetch_evt;
   logic drop_evt;

   assign fetch_evt = (state_q == ST_HOLD) && id_ready_i && !flush_i;
   assign drop_evt  = ((state_q == ST_WAIT) && imem_rsp_valid_i && (drop_q || flush_i)) ||
                      ((state_q == ST_HOLD) && flush_i);

   ifu_perf_cnt u_perf_cnt (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .fetch_inc_i (fetch_evt),
      .drop_inc_i  (drop_evt),
      .fetch_cnt_o (fetch_cnt_o),
      .drop_cnt_o  (drop_cnt_o)
   );
`endif

endmodule

// File: tb/tb_pipe_ifu.sv
// Directed-vector bench for pipe_ifu; memory and decode handshakes driven cycle by cycle.
module tb_pipe_ifu;
   import liang_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        flush_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        imem_req_valid_o;
   logic [31:0] imem_req_addr_o;
   logic        imem_req_ready_i = 1'b0;
   logic        imem_rsp_valid_i = 1'b0;
   logic [31:0] imem_rsp_data_i = '0;
   ifToId_t     ifToId_o;
   logic        if_valid_o;
   logic        id_ready_i = 1'b0;
`ifdef IFU_PERF_CNT_EN
   logic [31:0] fetch_cnt_o;
   logic [31:0] drop_cnt_o;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   pipe_ifu #(.RESET_PC(32'h8000_0000)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .flush_i          (flush_i),
      .redirect_pc_i    (redirect_pc_i),
      .imem_req_valid_o (imem_req_valid_o),
      .imem_req_addr_o  (imem_req_addr_o),
      .imem_req_ready_i (imem_req_ready_i),
      .imem_rsp_valid_i (imem_rsp_valid_i),
      .imem_rsp_data_i  (imem_rsp_data_i),
      .ifToId_o         (ifToId_o),
      .if_valid_o       (if_valid_o),
      .id_ready_i       (id_ready_i)
`ifdef IFU_PERF_CNT_EN
      ,
      .fetch_cnt_o      (fetch_cnt_o),
      .drop_cnt_o       (drop_cnt_o)
`endif
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // From REQ: accept the request, return data one cycle later, end in HOLD.
   task automatic fetch_to_hold(input logic [31:0] data);
      imem_req_ready_i = 1'b1;
      tick();
      imem_req_ready_i = 1'b0;
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = data;
      tick();
      imem_rsp_valid_i = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      tick();
      tick();
      n_vec++;
      if (if_valid_o !== 1'b0 || imem_req_valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_valids: if_valid=%b req_valid=%b required 0/0", if_valid_o, imem_req_valid_o);
      end
      n_vec++;
      if (imem_req_addr_o !== 32'h8000_0000 || ifToId_o !== 64'd0) begin
         n_err++;
         $display("FAIL reset_data: addr=%h ifToId=%h required 80000000/0", imem_req_addr_o, ifToId_o);
      end
   endtask

   task automatic test_first_fetch();
      rst_i = 1'b0;
      #1;
      n_vec++;
      if (imem_req_valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL idle_no_req: req_valid=%b required 0", imem_req_valid_o);
      end
      tick();
      n_vec++;
      if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0000) begin
         n_err++;
         $display("FAIL first_req: valid=%b addr=%h required 1/80000000", imem_req_valid_o, imem_req_addr_o);
      end
      imem_req_ready_i = 1'b1;
      tick();
      imem_req_ready_i = 1'b0;
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = 32'h0000_0013;
      #1;
      n_vec++;
      if (if_valid_o !== 1'b0 || imem_req_valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL wait_quiet: if_valid=%b req_valid=%b required 0/0", if_valid_o, imem_req_valid_o);
      end
      tick();
      imem_rsp_valid_i = 1'b0;
      #1;
      n_vec++;
      if (if_valid_o !== 1'b1 || ifToId_o !== {32'h8000_0000, 32'h0000_0013}) begin
         n_err++;
         $display("FAIL first_handoff: valid=%b ifToId=%h required 1/8000000000000013", if_valid_o, ifToId_o);
      end
      id_ready_i = 1'b1;
      tick();
      id_ready_i = 1'b0;
      #1;
      n_vec++;
      if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0004 || if_valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL second_req: valid=%b addr=%h if_valid=%b required 1/80000004/0",
                  imem_req_valid_o, imem_req_addr_o, if_valid_o);
      end
   endtask

   task automatic test_stall();
      fetch_to_hold(32'hDEAD_0001);
      id_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if (if_valid_o !== 1'b1 || ifToId_o !== {32'h8000_0004, 32'hDEAD_0001} || imem_req_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL stall_hold[%0d]: valid=%b ifToId=%h req_valid=%b required 1/80000004dead0001/0",
                     i, if_valid_o, ifToId_o, imem_req_valid_o);
         end
         tick();
      end
      id_ready_i = 1'b1;
      tick();
      id_ready_i = 1'b0;
      #1;
      n_vec++;
      if (if_valid_o !== 1'b0 || imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0008) begin
         n_err++;
         $display("FAIL stall_release: if_valid=%b req_valid=%b addr=%h required 0/1/80000008",
                  if_valid_o, imem_req_valid_o, imem_req_addr_o);
      end
   endtask

   task automatic test_flush_wait();
      imem_req_ready_i = 1'b1;
      tick();
      imem_req_ready_i = 1'b0;
      flush_i       = 1'b1;
      redirect_pc_i = 32'h8000_0102;
      tick();
      flush_i = 1'b0;
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = 32'hBAD0_BAD0;
      #1;
      n_vec++;
      if (if_valid_o !== 1'b0 || imem_req_valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL flush_wait_pending: if_valid=%b req_valid=%b required 0/0", if_valid_o, imem_req_valid_o);
      end
      tick();
      imem_rsp_valid_i = 1'b0;
      #1;
      n_vec++;
      if (if_valid_o !== 1'b0 || imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0100) begin
         n_err++;
         $display("FAIL flush_wait_redirect: if_valid=%b req_valid=%b addr=%h required 0/1/80000100",
                  if_valid_o, imem_req_valid_o, imem_req_addr_o);
      end
      fetch_to_hold(32'h0000_0011);
      n_vec++;
      if (if_valid_o !== 1'b1 || ifToId_o !== {32'h8000_0100, 32'h0000_0011}) begin
         n_err++;
         $display("FAIL flush_wait_next: valid=%b ifToId=%h required 1/8000010000000011", if_valid_o, ifToId_o);
      end
      id_ready_i = 1'b1;
      tick();
      id_ready_i = 1'b0;
      #1;
   endtask

   task automatic test_flush_hold();
      fetch_to_hold(32'h0000_0022);
      flush_i       = 1'b1;
      redirect_pc_i = 32'h0000_2003;
      #1;
      n_vec++;
      if (if_valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL flush_hold_mask: if_valid=%b required 0", if_valid_o);
      end
      tick();
      flush_i = 1'b0;
      #1;
      n_vec++;
      if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h0000_2000 || if_valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL flush_hold_redirect: req_valid=%b addr=%h if_valid=%b required 1/00002000/0",
                  imem_req_valid_o, imem_req_addr_o, if_valid_o);
      end
   endtask

   task automatic test_wrap();
      flush_i       = 1'b1;
      redirect_pc_i = 32'hFFFF_FFFC;
      tick();
      flush_i = 1'b0;
      #1;
      n_vec++;
      if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'hFFFF_FFFC) begin
         n_err++;
         $display("FAIL flush_req_readdr: valid=%b addr=%h required 1/fffffffc", imem_req_valid_o, imem_req_addr_o);
      end
      fetch_to_hold(32'h0000_0077);
      n_vec++;
      if (ifToId_o !== {32'hFFFF_FFFC, 32'h0000_0077}) begin
         n_err++;
         $display("FAIL wrap_handoff: ifToId=%h required fffffffc00000077", ifToId_o);
      end
      id_ready_i = 1'b1;
      tick();
      id_ready_i = 1'b0;
      #1;
      n_vec++;
      if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h0000_0000) begin
         n_err++;
         $display("FAIL wrap_addr: valid=%b addr=%h required 1/00000000", imem_req_valid_o, imem_req_addr_o);
      end
   endtask

   task automatic test_flush_rsp();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      tick();
      imem_req_ready_i = 1'b1;
      tick();
      imem_req_ready_i = 1'b0;
      flush_i          = 1'b1;
      redirect_pc_i    = 32'h0000_1000;
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = 32'hBAD2_BAD2;
      #1;
      n_vec++;
      if (if_valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL flush_rsp_mask: if_valid=%b required 0", if_valid_o);
      end
      tick();
      flush_i          = 1'b0;
      imem_rsp_valid_i = 1'b0;
      #1;
      n_vec++;
      if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h0000_1000 || if_valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL flush_rsp_redirect: req_valid=%b addr=%h if_valid=%b required 1/00001000/0",
                  imem_req_valid_o, imem_req_addr_o, if_valid_o);
      end
`ifdef IFU_PERF_CNT_EN
      n_vec++;
      if (drop_cnt_o !== 32'd1 || fetch_cnt_o !== 32'd0) begin
         n_err++;
         $display("FAIL flush_rsp_counts: drop=%0d fetch=%0d required 1/0", drop_cnt_o, fetch_cnt_o);
      end
`endif
   endtask

   task automatic test_reset_in_wait();
      fetch_to_hold(32'h0000_0055);
      id_ready_i = 1'b1;
      tick();
      id_ready_i = 1'b0;
      imem_req_ready_i = 1'b1;
      tick();
      imem_req_ready_i = 1'b0;
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = 32'h1A7E_1A7E;
      #1;
      n_vec++;
      if (if_valid_o !== 1'b0 || imem_req_valid_o !== 1'b0 || imem_req_addr_o !== 32'h8000_0000 ||
          ifToId_o !== 64'd0) begin
         n_err++;
         $display("FAIL rst_wait_state: if_valid=%b req_valid=%b addr=%h ifToId=%h required 0/0/80000000/0",
                  if_valid_o, imem_req_valid_o, imem_req_addr_o, ifToId_o);
      end
      tick();
      imem_rsp_valid_i = 1'b0;
      #1;
      n_vec++;
      if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0000 || if_valid_o !== 1'b0 ||
          ifToId_o !== 64'd0) begin
         n_err++;
         $display("FAIL rst_late_rsp: req_valid=%b addr=%h if_valid=%b ifToId=%h required 1/80000000/0/0",
                  imem_req_valid_o, imem_req_addr_o, if_valid_o, ifToId_o);
      end
      tick();
      n_vec++;
      if (imem_req_valid_o !== 1'b1 || if_valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL rst_still_req: req_valid=%b if_valid=%b required 1/0", imem_req_valid_o, if_valid_o);
      end
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_stall();
      test_flush_wait();
      test_flush_hold();
      test_wrap();
      test_flush_rsp();
      test_reset_in_wait();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
